// File: rtl/pipe_stage_skid.sv
// rtl/pipe_stage_skid.sv - pipeline stage register with 2-entry skid buffer, flush/freeze; optional stats via PIPE_STAGE_STATS_EN
module pipe_stage_skid #(
    parameter int unsigned            DATA_W      = 32,
    parameter int unsigned            PC_W        = 32,
    parameter logic [DATA_W-1:0]      FLUSH_INSTR = '0,
    parameter int unsigned            STAT_W      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              freeze,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_instr,
    input  logic [PC_W-1:0]   in_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_instr,
    output logic [PC_W-1:0]   out_pc,
    output logic [1:0]        occupancy
`ifdef PIPE_STAGE_STATS_EN
    ,
    output logic [STAT_W-1:0] stall_cnt,
    output logic [STAT_W-1:0] flush_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    // Counter width must be usable even when the statistics are compiled out.
    if (STAT_W < 1) begin : g_bad_stat_w
        $error("pipe_stage_skid: STAT_W must be at least 1");
    end

    state_t            state_q, state_d;
    logic [DATA_W-1:0] m_instr_q, m_instr_d;
    logic [PC_W-1:0]   m_pc_q, m_pc_d;
    logic [DATA_W-1:0] s_instr_q, s_instr_d;
    logic [PC_W-1:0]   s_pc_q, s_pc_d;
    logic              accept;
    logic              deliver;

    // Handshake: ready depends only on registered state and freeze, never on the valid/ready inputs.
    always_comb begin
        in_ready  = (state_q != ST_TWO) && !freeze;
        out_valid = (state_q != ST_EMPTY);
        accept    = in_valid && in_ready;
        deliver   = out_valid && out_ready && !freeze;
        out_instr = m_instr_q;
        out_pc    = m_pc_q;
        occupancy = state_q;
    end

    // Next-state and datapath: flush wins over everything, freeze holds, otherwise move entries M/S.
    always_comb begin
        state_d   = state_q;
        m_instr_d = m_instr_q;
        m_pc_d    = m_pc_q;
        s_instr_d = s_instr_q;
        s_pc_d    = s_pc_q;
        if (flush) begin
            state_d   = ST_EMPTY;
            m_instr_d = FLUSH_INSTR;
            m_pc_d    = '0;
            s_instr_d = '0;
            s_pc_d    = '0;
        end else if (!freeze) begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_d   = ST_ONE;
                        m_instr_d = in_instr;
                        m_pc_d    = in_pc;
                    end
                end
                ST_ONE: begin
                    if (accept && deliver) begin
                        m_instr_d = in_instr;
                        m_pc_d    = in_pc;
                    end else if (accept) begin
                        state_d   = ST_TWO;
                        s_instr_d = in_instr;
                        s_pc_d    = in_pc;
                    end else if (deliver) begin
                        // M keeps its last value; out_valid drops so it is not seen again.
                        state_d = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (deliver) begin
                        state_d   = ST_ONE;
                        m_instr_d = s_instr_q;
                        m_pc_d    = s_pc_q;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    // State and entry registers with asynchronous reset to the bubble encoding.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_EMPTY;
            m_instr_q <= FLUSH_INSTR;
            m_pc_q    <= '0;
            s_instr_q <= '0;
            s_pc_q    <= '0;
        end else begin
            state_q   <= state_d;
            m_instr_q <= m_instr_d;
            m_pc_q    <= m_pc_d;
            s_instr_q <= s_instr_d;
            s_pc_q    <= s_pc_d;
        end
    end

`ifdef PIPE_STAGE_STATS_EN
    logic [STAT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [STAT_W-1:0] flush_cnt_q, flush_cnt_d;

    // Saturating event counters: stalled-while-holding cycles and flushes that discarded work.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (freeze && !flush && (state_q != ST_EMPTY) && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        if (flush && (state_q != ST_EMPTY) && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + 1'b1;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb/tb_pipe_stage_skid.sv - randomized and directed checks of pipe_stage_skid against a queue model
module tb_pipe_stage_skid;

    localparam int unsigned DW     = 32;
    localparam int unsigned PW     = 32;
    localparam logic [31:0] FLUSHV = 32'hDEAD_0013;
    localparam int unsigned SW     = 4;
    localparam int          SMAX   = (1 << SW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic          freeze = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_instr = '0;
    logic [PW-1:0] in_pc = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_instr;
    logic [PW-1:0] out_pc;
    logic [1:0]    occupancy;
`ifdef PIPE_STAGE_STATS_EN
    logic [SW-1:0] stall_cnt;
    logic [SW-1:0] flush_cnt;
`endif

    pipe_stage_skid #(
        .DATA_W(DW), .PC_W(PW), .FLUSH_INSTR(FLUSHV), .STAT_W(SW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .freeze(freeze),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
        .occupancy(occupancy)
`ifdef PIPE_STAGE_STATS_EN
        , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Model: entries held in arrival order, front is what the stage presents.
    logic [63:0] mq[$];
    logic [31:0] dlog[$];
    logic [31:0] held_instr = FLUSHV;
    logic [31:0] held_pc = '0;
    int          m_stall = 0;
    int          m_flush = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        held_instr = FLUSHV;
        held_pc    = '0;
        m_stall    = 0;
        m_flush    = 0;
    endtask

    task automatic check_outputs();
        check("out_valid", 64'(out_valid), 64'(mq.size() != 0));
        check("out_instr", 64'(out_instr), 64'(held_instr));
        check("out_pc", 64'(out_pc), 64'(held_pc));
        check("occupancy", 64'(occupancy), 64'(mq.size()));
`ifdef PIPE_STAGE_STATS_EN
        check("stall_cnt", 64'(stall_cnt), 64'(m_stall));
        check("flush_cnt", 64'(flush_cnt), 64'(m_flush));
`endif
    endtask

    // One clock: drive inputs, check before the edge, advance the model across the edge.
    task automatic cycle(input logic iv, input logic [31:0] ii, input logic [31:0] ip,
                         input logic ordy, input logic frz, input logic fl);
        logic exp_rdy, acc, del;
        int   sz;
        in_valid = iv; in_instr = ii; in_pc = ip;
        out_ready = ordy; freeze = frz; flush = fl;
        @(negedge clk);
        sz      = mq.size();
        exp_rdy = (sz < 2) && !frz;
        check("in_ready", 64'(in_ready), 64'(exp_rdy));
        check_outputs();
        acc = iv && exp_rdy;
        del = (sz != 0) && ordy && !frz;
        @(posedge clk);
        #1;
        if (fl) begin
            if (sz > 0 && m_flush < SMAX) m_flush++;
            mq.delete();
            held_instr = FLUSHV;
            held_pc    = '0;
        end else begin
            if (frz && sz > 0 && m_stall < SMAX) m_stall++;
            if (del) begin
                dlog.push_back(mq[0][31:0]);
                void'(mq.pop_front());
            end
            if (acc) mq.push_back({ip, ii});
            if (mq.size() != 0) begin
                held_instr = mq[0][31:0];
                held_pc    = mq[0][63:32];
            end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; freeze = 1'b0; flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        rst_n = 1'b1;
    endtask

    initial begin
        do_reset();
        // Reset state
        @(negedge clk);
        check_outputs();
        check("rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;

        // Streaming: back-to-back with out_ready=1
        dlog.delete();
        for (int i = 0; i < 8; i++) cycle(1'b1, 32'hE3A0_0001 + 32'(i), 32'(4 * i), 1'b1, 1'b0, 1'b0);
        cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        check("stream_count", 64'(dlog.size()), 64'd8);
        for (int i = 0; i < 8 && i < dlog.size(); i++)
            check("stream_order", 64'(dlog[i]), 64'(32'hE3A0_0001 + 32'(i)));

        // Backpressure: A into M, B into S, C held upstream, then drain
        dlog.delete();
        cycle(1'b1, 32'hA, 32'h100, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'hB, 32'h104, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'hC, 32'h108, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'hC, 32'h108, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 32'hC, 32'h108, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        check("bp_count", 64'(dlog.size()), 64'd3);
        if (dlog.size() == 3) begin
            check("bp_first", 64'(dlog[0]), 64'hA);
            check("bp_second", 64'(dlog[1]), 64'hB);
            check("bp_third", 64'(dlog[2]), 64'hC);
        end

        // Freeze with one entry held at pc 0x40
        do_reset();
        cycle(1'b1, 32'h1234, 32'h40, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b1, 32'h5555, 32'h44, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        check("frz_pc", 64'(out_pc), 64'h40);
        check("frz_occ", 64'(occupancy), 64'd1);
`ifdef PIPE_STAGE_STATS_EN
        check("frz_stall3", 64'(stall_cnt), 64'd3);
`endif
        @(posedge clk);
        #1;

        // Flush beats freeze and accept with two entries held
        cycle(1'b1, 32'h2222, 32'h48, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'h3333, 32'h4C, 1'b1, 1'b1, 1'b1);
        @(negedge clk);
        check("fl_occ", 64'(occupancy), 64'd0);
        check("fl_valid", 64'(out_valid), 64'd0);
        check("fl_instr", 64'(out_instr), 64'(FLUSHV));
`ifdef PIPE_STAGE_STATS_EN
        check("fl_cnt", 64'(flush_cnt), 64'd1);
        check("fl_stall", 64'(stall_cnt), 64'd3);
`endif
        @(posedge clk);
        #1;

        // Saturation of the stall counter
        cycle(1'b1, 32'h7777, 32'h80, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) cycle(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
`ifdef PIPE_STAGE_STATS_EN
        @(negedge clk);
        check("sat_stall", 64'(stall_cnt), 64'(SMAX));
        @(posedge clk);
        #1;
`endif

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 1)), $urandom, $urandom,
                  1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 7) == 0),
                  1'($urandom_range(0, 15) == 0));
        end

        // Asynchronous reset mid-cycle with two entries held
        cycle(1'b1, 32'hAA, 32'h10, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'hBB, 32'h14, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'hCC, 32'h18, 1'b0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("arst_valid", 64'(out_valid), 64'd0);
        check("arst_instr", 64'(out_instr), 64'(FLUSHV));
        check("arst_pc", 64'(out_pc), 64'd0);
        check("arst_occ", 64'(occupancy), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
